// File: rtl/color_sensor_pkg.sv
// Shared types and constants for the colour-sensor scan controller.
package color_sensor_pkg;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StGate,
    StCommit
  } state_e;

  // Scan order is the numeric order of this type.
  typedef enum logic [1:0] {
    ChRed,
    ChGreen,
    ChBlue,
    ChClear
  } chan_e;

  function automatic logic [1:0] filt_code(input chan_e ch);
    logic [1:0] code;
    unique case (ch)
      ChRed:   code = FILT_RED;
      ChGreen: code = FILT_GREEN;
      ChBlue:  code = FILT_BLUE;
      ChClear: code = FILT_CLEAR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/edge_counter.sv
// Synchronises the sensor frequency output and counts its rising edges with saturation.
// count/sat present the next-state value, so an edge seen this cycle is already included.
module edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             sensor,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic             sync1_q, sync2_q, prev_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (en && rise) begin
      if (&cnt_q) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign count = cnt_d;
  assign sat   = sat_d;

endmodule

// File: rtl/color_scan_ctrl.sv
// Steps the sensor filter through R,G,B,C, gates edge counts per channel and
// publishes the four counts with a one-cycle done pulse.
module color_scan_ctrl
  import color_sensor_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned GATE_CYC   = 100000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [1:0]       scale,
  input  logic             sensor,
  output logic [1:0]       scale_sel,
  output logic [1:0]       filter_sel,
  output logic             sensor_oe_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] green,
  output logic [CNT_W-1:0] blue,
  output logic [CNT_W-1:0] clear,
  output logic [3:0]       overflow
);

  localparam int unsigned TMAX = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYC - 1);

  state_e           state;
  chan_e            chan;
  logic [1:0]       chan_idx_nx;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] work_r, work_g, work_b;
  logic [2:0]       work_ov;
  logic [CNT_W-1:0] ec_count;
  logic             ec_sat, ec_clr, ec_en;
  logic             launch;

  assign ec_en       = (state == StGate);
  assign ec_clr      = (state != StGate);
  assign chan_idx_nx = chan + 2'd1;
  assign launch      = ((state == StIdle) && start) || ((state == StCommit) && continuous);

  edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (ec_clr),
    .en    (ec_en),
    .sensor(sensor),
    .count (ec_count),
    .sat   (ec_sat)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= StIdle;
      chan        <= ChRed;
      timer       <= '0;
      filter_sel  <= FILT_RED;
      scale_sel   <= 2'b00;
      sensor_oe_n <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      clear       <= '0;
      overflow    <= '0;
      work_r      <= '0;
      work_g      <= '0;
      work_b      <= '0;
      work_ov     <= '0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        state       <= StSettle;
        chan        <= ChRed;
        timer       <= '0;
        filter_sel  <= FILT_RED;
        scale_sel   <= scale;
        sensor_oe_n <= 1'b0;
        busy        <= 1'b1;
        work_r      <= '0;
        work_g      <= '0;
        work_b      <= '0;
        work_ov     <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            scale_sel   <= 2'b00;
            sensor_oe_n <= 1'b1;
            busy        <= 1'b0;
          end
          StSettle: begin
            if (timer == SETTLE_LAST) begin
              timer <= '0;
              state <= StGate;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          StGate: begin
            if (timer == GATE_LAST) begin
              timer <= '0;
              // ec_count already includes an edge arriving in this final cycle.
              unique case (chan)
                ChRed:   begin work_r <= ec_count; work_ov[0] <= ec_sat; end
                ChGreen: begin work_g <= ec_count; work_ov[1] <= ec_sat; end
                ChBlue:  begin work_b <= ec_count; work_ov[2] <= ec_sat; end
                ChClear: begin
                  red      <= work_r;
                  green    <= work_g;
                  blue     <= work_b;
                  clear    <= ec_count;
                  overflow <= {ec_sat, work_ov};
                  done     <= 1'b1;
                end
              endcase
              if (chan == ChClear) begin
                state <= StCommit;
              end else begin
                chan       <= chan_e'(chan_idx_nx);
                filter_sel <= filt_code(chan_e'(chan_idx_nx));
                state      <= StSettle;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          StCommit: begin
            state       <= StIdle;
            scale_sel   <= 2'b00;
            sensor_oe_n <= 1'b1;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/color_scan_ctrl.md
Name: color_scan_ctrl

Overview:
Sequencer for the colour-sensor frequency output (TCS3200-style light-to-frequency device). It steps the photodiode filter select through red, green, blue and clear. For each channel it waits a settle time, then counts rising edges of `sensor` over a fixed gate window. It publishes four result words with a done pulse and sits between the sensor pins and the downstream colour classification logic.

Parameters:
- SETTLE_CYC, 1000: clk cycles waited after each filter change before counting.
- GATE_CYC, 100000: clk cycles in each counting window.
- CNT_W, 16: width of each result count.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-low reset.
- start, in, 1: one-cycle request to begin a scan; sampled only in IDLE.
- continuous, in, 1: when 1 at scan end, the next scan starts immediately.
- scale, in, 2: requested output scaling {S0,S1}; latched at scan start.
- sensor, in, 1: asynchronous frequency output from the sensor.
- scale_sel, out, 2: drives {S0,S1} pins.
- filter_sel, out, 2: drives {S2,S3} pins.
- sensor_oe_n, out, 1: sensor output enable, active low.
- busy, out, 1: high while a scan is in progress.
- done, out, 1: one-cycle pulse when new results are committed.
- red, green, blue, clear, out, CNT_W each: committed edge counts.
- overflow, out, 4: saturation flags {clear,blue,green,red} for the last scan.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state IDLE.
  - filter_sel=00, scale_sel=00 (sensor power-down), sensor_oe_n=1.
  - busy=0, done=0, all counts=0, overflow=0.
  - Reset mid-scan aborts the scan; partial counts are discarded.
- Input synchronisation: `sensor` passes through a 2-FF synchroniser plus one history FF. A rising edge is sync=1 and prev=0. Edge latency is 3 clk; this delay is not compensated.
- Channel order and filter codes: RED=00, GREEN=11, BLUE=01, CLEAR=10.
- States: IDLE, SETTLE, GATE, COMMIT.
- IDLE:
  - scale_sel=00, sensor_oe_n=1, busy=0.
  - On start=1: latch scale, select channel RED, clear working counters, go to SETTLE.
- SETTLE:
  - filter_sel = current channel code, scale_sel = latched scale, sensor_oe_n=0, busy=1.
  - Stays exactly SETTLE_CYC cycles, then goes to GATE.
  - Edges during SETTLE are ignored.
- GATE:
  - Stays exactly GATE_CYC cycles; each detected edge increments that channel's working counter, including an edge detected in the final gate cycle.
  - The counter saturates at 2^CNT_W-1 and sets the channel's working overflow bit.
  - At the end of the window: if the channel is CLEAR, go to COMMIT; otherwise advance the channel and go to SETTLE.
- COMMIT (1 cycle):
  - Copy working counters and overflow bits to the outputs; assert done for this cycle.
  - If continuous=1: latch `scale` again, clear working counters, select RED, go to SETTLE with busy held high.
  - Otherwise go to IDLE.
- Result outputs change only in COMMIT and hold stable through the next scan.
- Latency: start at cycle 0 gives busy=1 from cycle 1; done is high at cycle 4*(SETTLE_CYC+GATE_CYC)+1.
- start while busy is ignored (no queuing).
- scale=00 is legal; the sensor is powered down and all counts read 0.
- Internal cycle timer width is clog2(max(SETTLE_CYC,GATE_CYC)). SETTLE_CYC and GATE_CYC must each be ≥1.

Decomposition:
- Package color_sensor_pkg holds:
  - filter code constants FILT_RED/GREEN/BLUE/CLEAR;
  - the state enum;
  - the channel index type (0..3, order R,G,B,C).
- Sub-module edge_counter contains the synchroniser, edge detect and saturating counter, with ports clk, reset, clr, en, sensor, count, sat. One instance is used, time-shared across channels; the controller stores results per channel.

Test Plan:
All scenarios use SETTLE_CYC=4, GATE_CYC=20, CNT_W=8, and `sensor` with period 4 clk (2 high, 2 low) unless noted.
1. Single scan, scale=10 → busy rises next cycle; filter_sel goes 00,11,01,10 for 24 cycles each; done pulses at cycle 97; red=green=blue=clear=5, overflow=0000, scale_sel=10 while busy, then 00.
2. sensor held at 0 during the BLUE window only, toggling otherwise → blue=0, other three counts=5; previous results stay visible until the done cycle.
3. CNT_W=2, sensor period 2 clk → all counts=3, overflow=1111.
4. continuous=1 → done pulses every 97 cycles with busy never dropping; set continuous=0 mid-scan → the following done is the last one and the block returns to IDLE.
5. Drive start again at cycle 30, then reset=0 for 1 cycle at cycle 50 → the second start has no effect; after reset, all outputs are at reset values with no done pulse; a fresh start completes normally with counts=5.
6. Edge placed in the last gate cycle of the RED window (after synchroniser delay) → it is counted in red; an edge occurring during SETTLE of GREEN is not counted in green.
